// File: rtl/media_fetch_pkg.sv
// media_fetch_pkg: shared state encoding, command framing and parameter defaults for media_fetch_ctrl
package media_fetch_pkg;
  typedef enum logic [2:0] {IDLE, SELECT, CMD, XFER, GAP} state_e;
  localparam logic [4:0] CMD_PREFIX = 5'b10100;
  localparam int CMD_W = 8;
  localparam int NUM_CH_DEF = 2;
  localparam int DATA_W_DEF = 8;
  localparam int BURST_LEN_DEF = 64;
  localparam int GAP_TICKS_DEF = 4;
endpackage

// File: rtl/media_fetch_ctrl_spi_shift_unit.sv
// spi_shift_unit: shared TX/RX shift register with a wrapping bit counter, advanced once per SPI bit period
module spi_shift_unit import media_fetch_pkg::*; #(
  parameter int W = CMD_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic                 load_i,
  input  logic [W-1:0]         load_val_i,
  input  logic                 sin_i,
  input  logic [$clog2(W)-1:0] last_i,
  output logic [W-1:0]         sr_o,
  output logic                 wrap_o
);
  logic [W-1:0]         sr_q;
  logic [$clog2(W)-1:0] cnt_q;
  assign sr_o   = sr_q;
  assign wrap_o = en_i && (cnt_q == last_i);
  // load a command or shift one bit out/in, counting bits up to last_i
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      sr_q  <= load_val_i;
      cnt_q <= '0;
    end else if (en_i) begin
      sr_q  <= {sr_q[W-2:0], sin_i};
      cnt_q <= wrap_o ? '0 : cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/media_fetch_ctrl.sv
// media_fetch_ctrl: SPI burst fetcher feeding NUM_CH sinks; MEDIA_FETCH_PRIORITY_EN selects strict priority instead of round-robin
module media_fetch_ctrl import media_fetch_pkg::*; #(
  parameter int NUM_CH    = NUM_CH_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int GAP_TICKS = GAP_TICKS_DEF
) (
  input  logic              CLK_40,
  input  logic              reset,
  input  logic              SPI_clk_en,
  input  logic              enable,
  input  logic              MISO,
  input  logic [NUM_CH-1:0] ch_ready,
  output logic              MOSI,
  output logic              chip_select,
  output logic [DATA_W-1:0] wr_data,
  output logic [NUM_CH-1:0] wr_valid,
  output logic [NUM_CH-1:0] burst_done,
  output logic              busy
);
  localparam int GW   = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int SR_W = DATA_W > CMD_W ? DATA_W : CMD_W;
  localparam int CW   = $clog2(SR_W);
  localparam int WCW  = $clog2(BURST_LEN + 1);
  localparam logic [NUM_CH-1:0] CH_ONE = NUM_CH'(1);
  state_e            state_q, state_d;
  logic [GW-1:0]     last_grant_q, last_grant_d, grant_idx, rr_idx;
  logic [WCW-1:0]    word_cnt_q, word_cnt_d;
  logic [7:0]        gap_cnt_q, gap_cnt_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [NUM_CH-1:0] wr_valid_q, wr_valid_d, burst_done_q, burst_done_d, ch_sel;
  logic              grant_ok, load, shift_en, wrap, word_done;
  logic [CMD_W-1:0]  cmd;
  logic [SR_W-1:0]   sr, rx_word;
  assign ch_sel    = CH_ONE << last_grant_q;
  assign word_done = word_cnt_q == WCW'(BURST_LEN);
  assign shift_en  = SPI_clk_en && (state_q == CMD || (state_q == XFER && !word_done));
  assign cmd       = {CMD_PREFIX, 3'(grant_idx)};
  assign rx_word   = {sr[SR_W-2:0], MISO};
  assign MOSI        = state_q == CMD ? sr[SR_W-1] : 1'b1;
  assign chip_select = !(state_q == CMD || state_q == XFER);
  assign busy        = state_q != IDLE;
  assign wr_data     = wr_data_q;
  assign wr_valid    = wr_valid_q;
  assign burst_done  = burst_done_q;
  spi_shift_unit #(.W(SR_W)) u_shift (
    .clk        (CLK_40),
    .rst        (reset),
    .en_i       (shift_en),
    .load_i     (load),
    .load_val_i (SR_W'(cmd) << (SR_W - CMD_W)),
    .sin_i      (MISO),
    .last_i     (state_q == CMD ? CW'(CMD_W - 1) : CW'(DATA_W - 1)),
    .sr_o       (sr),
    .wrap_o     (wrap)
  );
  // pick the next ready channel; the last assignment in the descending scan wins
  always_comb begin
    grant_ok  = 1'b0;
    grant_idx = '0;
    rr_idx    = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
`ifdef MEDIA_FETCH_PRIORITY_EN
      rr_idx = GW'(i - 1);
`else
      rr_idx = GW'((int'(last_grant_q) + i) % NUM_CH);
`endif
      if (ch_ready[rr_idx]) begin
        grant_ok  = 1'b1;
        grant_idx = rr_idx;
      end
    end
  end
  // burst sequencing: select, command, data words, then inter-burst gap
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    word_cnt_d   = word_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    wr_data_d    = wr_data_q;
    wr_valid_d   = '0;
    burst_done_d = '0;
    load         = 1'b0;
    case (state_q)
      IDLE:   state_d = enable ? SELECT : IDLE;
      SELECT: if (!enable) state_d = IDLE;
              else if (grant_ok) begin
                state_d      = CMD;
                last_grant_d = grant_idx;
                word_cnt_d   = '0;
                load         = 1'b1;
              end
      CMD:    if (wrap) state_d = XFER;
      XFER:   if (word_done) begin
                state_d      = GAP;
                burst_done_d = ch_sel;
                gap_cnt_d    = '0;
              end else if (wrap) begin
                wr_data_d  = rx_word[DATA_W-1:0];
                wr_valid_d = ch_sel;
                word_cnt_d = word_cnt_q + 1'b1;
              end
      GAP:    if (SPI_clk_en) begin
                gap_cnt_d = gap_cnt_q == 8'(GAP_TICKS - 1) ? '0 : gap_cnt_q + 1'b1;
                if (gap_cnt_q == 8'(GAP_TICKS - 1)) state_d = enable ? SELECT : IDLE;
              end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers
  always_ff @(posedge CLK_40) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GW'(NUM_CH - 1);
      word_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      wr_data_q    <= '0;
      wr_valid_q   <= '0;
      burst_done_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      word_cnt_q   <= word_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      wr_data_q    <= wr_data_d;
      wr_valid_q   <= wr_valid_d;
      burst_done_q <= burst_done_d;
    end
  end
endmodule

// File: tb/tb_media_fetch_ctrl.sv
// tb_media_fetch_ctrl: SPI slave model with word scoreboard plus a table of burst grant vectors
module tb_media_fetch_ctrl;
  localparam int NC = 2;
  localparam int DW = 8;
  localparam int BL = 64;
  localparam int GT = 4;
  logic          clk, reset, SPI_clk_en, enable, MISO, MOSI, chip_select, busy;
  logic [NC-1:0] ch_ready, wr_valid, burst_done;
  logic [DW-1:0] wr_data;
  media_fetch_ctrl #(.NUM_CH(NC), .DATA_W(DW), .BURST_LEN(BL), .GAP_TICKS(GT)) dut (
    .CLK_40(clk), .reset(reset), .SPI_clk_en(SPI_clk_en), .enable(enable), .MISO(MISO),
    .ch_ready(ch_ready), .MOSI(MOSI), .chip_select(chip_select), .wr_data(wr_data),
    .wr_valid(wr_valid), .burst_done(burst_done), .busy(busy)
  );
  int checks = 0;
  int errors = 0;
  int wcount, done_cnt, exp_ch_v;
  logic [NC-1:0]    done_val;
  logic [7:0]       cmd_sr;
  logic [NC+DW-1:0] sb[$];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // SPI slave: serves command capture and the data stream, and scores every write strobe
  initial begin
    int tcnt, cyc, b, w;
    logic [7:0] wb;
    logic [NC+DW-1:0] e;
    logic tick;
    tcnt = 0;
    cyc = 0;
    SPI_clk_en = 1'b0;
    MISO = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_valid !== '0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL word_unexpected got=%b/%h", wr_valid, wr_data);
        end else begin
          e = sb.pop_front();
          if ({wr_valid, wr_data} !== e) begin
            errors++;
            $display("FAIL word got=%b/%h exp=%b/%h", wr_valid, wr_data, e[NC+DW-1:DW], e[DW-1:0]);
          end
        end
        wcount++;
      end
      if (burst_done !== '0) begin
        done_cnt++;
        done_val = burst_done;
      end
      tick = (cyc % 4) == 3;
      cyc++;
      if (chip_select) tcnt = 0;
      else if (tick) begin
        if (tcnt < 8) cmd_sr = {cmd_sr[6:0], MOSI};
        else begin
          b = tcnt - 8;
          w = b / 8;
          wb = 8'(w);
          MISO = wb[7 - (b % 8)];
          if (b % 8 == 7 && w < BL) sb.push_back({NC'(1) << exp_ch_v, wb});
        end
        tcnt++;
      end
      SPI_clk_en = tick;
    end
  end
  task automatic run_burst(input int ch, input int drop_at, input string name);
    int n;
    exp_ch_v = ch;
    wcount = 0;
    done_cnt = 0;
    done_val = '0;
    cmd_sr = '0;
    n = 0;
    while (done_cnt == 0 && n < 6000) begin
      if (drop_at >= 0 && wcount >= drop_at) enable = 1'b0;
      step();
      n++;
    end
    if (done_cnt == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got=no_burst_done exp=burst_done", name);
    end
    step();
    step();
    chk({name, "_cmd"}, cmd_sr, 32'hA0 | ch);
    chk({name, "_words"}, wcount, BL);
    chk({name, "_done_ch"}, done_val, NC'(1) << ch);
    chk({name, "_done_pulses"}, done_cnt, 1);
    chk({name, "_sb_empty"}, sb.size(), 0);
  endtask
  typedef struct {
    logic [NC-1:0] ready;
    int            exp_ch;
  } vec_t;
  initial begin
    vec_t tbl[7];
    int bad, n;
`ifdef MEDIA_FETCH_PRIORITY_EN
    tbl = '{'{2'b11, 0}, '{2'b11, 0}, '{2'b11, 0}, '{2'b10, 1}, '{2'b10, 1}, '{2'b01, 0}, '{2'b11, 0}};
`else
    tbl = '{'{2'b11, 0}, '{2'b11, 1}, '{2'b11, 0}, '{2'b10, 1}, '{2'b10, 1}, '{2'b01, 0}, '{2'b11, 1}};
`endif
    reset = 1'b1;
    enable = 1'b0;
    ch_ready = '0;
    exp_ch_v = 0;
    repeat (3) step();
    chk("rst_cs", chip_select, 1);
    chk("rst_mosi", MOSI, 1);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_burst_done", burst_done, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    repeat (5) step();
    chk("idle_busy", busy, 0);
    enable = 1'b1;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (chip_select !== 1'b1) bad++;
    end
    chk("noready_cs_high", bad, 0);
    chk("noready_busy", busy, 1);
    ch_ready = 2'b10;
    run_burst(1, -1, "first");
    for (int i = 0; i < 7; i++) begin
      ch_ready = tbl[i].ready;
      run_burst(tbl[i].exp_ch, -1, $sformatf("vec%0d", i));
    end
    ch_ready = 2'b11;
    run_burst(0, 10, "drop");
    chk("drop_gap_busy", busy, 1);
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    chk("drop_idle_busy", busy, 0);
    repeat (20) step();
    chk("drop_stay_idle", {busy, chip_select}, 2'b01);
    enable = 1'b1;
`ifdef MEDIA_FETCH_PRIORITY_EN
    exp_ch_v = 0;
`else
    exp_ch_v = 1;
`endif
    wcount = 0;
    done_cnt = 0;
    n = 0;
    while (wcount < 30 && n < 3000) begin
      step();
      n++;
    end
    chk("rst30_reached", wcount, 30);
    reset = 1'b1;
    step();
    chk("rst30_cs", chip_select, 1);
    chk("rst30_wr_valid", wr_valid, 0);
    chk("rst30_burst_done", burst_done, 0);
    chk("rst30_busy", busy, 0);
    sb.delete();
    reset = 1'b0;
    chk("rst30_no_done", done_cnt, 0);
    run_burst(0, -1, "post_rst");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/media_fetch_ctrl.md
MEDIA_FETCH_CTRL -- requirements
Module: media_fetch_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of sink channels (video bank, audio FIFO, ...), range 1..8.
REQ-002 SHALL have parameter DATA_W, default 8, bits per SPI word delivered to a sink.
REQ-003 SHALL have parameter BURST_LEN, default 64, words per burst, range 1..4096.
REQ-004 SHALL have parameter GAP_TICKS, default 4, SPI_clk_en pulses chip_select is held high between bursts, range 1..255.
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 SHALL have port CLK_40  input  1  system clock, the only clock.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port SPI_clk_en  input  1  one-cycle enable, one per SPI bit period.
REQ-009 SHALL have port enable  input  1  level; high permits new bursts.
REQ-010 SHALL have port MISO  input  1  serial data from the SD card/flash.
REQ-011 SHALL have port ch_ready  input  NUM_CH  sink can accept a full burst.
REQ-012 SHALL have port MOSI  output  1  serial command bit.
REQ-013 SHALL have port chip_select  output  1  active-low SPI select.
REQ-014 SHALL have port wr_data  output  DATA_W  assembled word.
REQ-015 SHALL have port wr_valid  output  NUM_CH  one-hot write strobe to the granted sink.
REQ-016 SHALL have port burst_done  output  NUM_CH  one-cycle pulse on the granted channel at burst end.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-018 SHALL implement states IDLE, SELECT, CMD, XFER, GAP.
REQ-019 IDLE -> SELECT on the first cycle enable is high; SELECT -> IDLE when enable is low.
REQ-020 SELECT, enable high: grant the first ch_ready channel searching round-robin from last_grant+1 (mod NUM_CH); if none, stay in SELECT with chip_select high.
REQ-021 SELECT -> CMD on grant; chip_select drops low the same cycle the state becomes CMD.
REQ-022 CMD: shift out the 8-bit command {5'b10100, grant[2:0]} MSB-first; MOSI updates on each SPI_clk_en; after the 8th pulse go to XFER.
REQ-023 XFER: sample MISO on each SPI_clk_en, MSB-first; on the DATA_W-th bit, wr_data and wr_valid[grant] assert for exactly the next CLK_40 cycle.
REQ-024 XFER: MOSI SHALL be held 1.
REQ-025 Word counter SHALL be $clog2(BURST_LEN+1) bits wide; after word BURST_LEN: burst_done[grant] pulses one cycle, chip_select goes high, state goes to GAP.
REQ-026 GAP: count GAP_TICKS SPI_clk_en pulses, then go to SELECT when enable is high, else to IDLE.
REQ-027 enable falling mid-CMD/XFER SHALL NOT abort; the burst completes.
REQ-028 ch_ready deasserting mid-burst SHALL be ignored; the sink guarantees BURST_LEN words of room when it asserts ch_ready.
REQ-029 With NUM_CH=1, round-robin SHALL degenerate to always granting channel 0.
REQ-030 Outside XFER, wr_valid SHALL be all-zero.

Reset
REQ-031 Reset SHALL give: state IDLE, chip_select 1, MOSI 1, wr_data 0, wr_valid 0, burst_done 0, busy 0, counters 0, last_grant NUM_CH-1.
REQ-032 Reset asserted mid-burst SHALL raise chip_select in the following cycle, with no wr_valid or burst_done pulse.

Configuration
REQ-033 Macro MEDIA_FETCH_PRIORITY_EN defined: SELECT SHALL grant the lowest-index ready channel (strict priority, channel 0 = audio); undefined: round-robin per REQ-020.

Structure
REQ-034 Package media_fetch_pkg SHALL hold the state enum, CMD_PREFIX (5'b10100), CMD_W (8) and the parameter defaults.
REQ-035 Sub-module spi_shift_unit SHALL hold the shared TX/RX shift register and bit counter, advanced by SPI_clk_en.

Verification
REQ-036 NUM_CH=2, ch_ready=2'b11, enable=1, MISO byte stream 0x00..0x3F -> grants alternate 0,1,0; 64 wr_valid pulses per burst with wr_data 0x00..0x3F; MOSI carries 0xA0 then 0xA1.
REQ-037 ch_ready=0 for 100 SPI ticks, then 2'b10 -> chip_select high throughout the wait; first command 0xA1.
REQ-038 enable dropped at word 10 -> all 64 words delivered, burst_done pulses, GAP runs, then IDLE with busy=0.
REQ-039 reset at word 30 -> chip_select=1 next cycle, no burst_done; the next burst starts at word 0 on channel 0.
REQ-040 MEDIA_FETCH_PRIORITY_EN defined, ch_ready=2'b11 held -> every grant is channel 0.
